wake_decision: RTL and testbench

//   Downstream of the fully-connected MAC stage. Accepts one packed vector of
//   NUM_CLASSES signed class scores per frame and finds the winning class
//   (argmax) by scanning one class per cycle. Counts consecutive wake-class

---
 rtl/wake_decision_pkg.sv | 16 +
 rtl/wake_hit_counter.sv | 45 ++++
 rtl/wake_decision.sv | 146 ++++++++++++++
 tb/tb_wake_decision.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wake_decision_pkg.sv
// Shared types and helpers for the wake decision block: FSM encoding and
// index-width helper used by both the top and the hit counter.
package wake_decision_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } wrd_state_e;

  // Bits needed to index n distinct values, never less than one.
  function automatic int class_bw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wake_hit_counter.sv
// Consecutive wake-hit counter: fires when the current hit completes a streak
// of HIT_COUNT qualifying frames, then re-arms. Advances only on a handshake.
module wake_hit_counter
  import wake_decision_pkg::*;
#(
  parameter int HIT_COUNT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hit_i,
  input  logic handshake_i,
  output logic wake_o
);

  localparam int CNT_BW = class_bw(HIT_COUNT);

  logic [CNT_BW-1:0] cnt_q, cnt_d;

  always_comb begin
    wake_o = hit_i && (cnt_q == CNT_BW'(HIT_COUNT - 1));
  end

  // The count never passes HIT_COUNT-1 because a firing frame clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (handshake_i) begin
      if (wake_o) begin
        cnt_d = '0;
      end else if (hit_i) begin
        cnt_d = cnt_q + CNT_BW'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wake_decision.sv
// Per-frame argmax over the class scores (one class per cycle) with a
// registered result beat and a consecutive wake-hit decision.
module wake_decision
  import wake_decision_pkg::*;
#(
  parameter int                     O_BW        = 24,
  parameter int                     NUM_CLASSES = 3,
  parameter int                     WAKE_CLASS  = 1,
  parameter logic signed [O_BW-1:0] THRESHOLD   = '0,
  parameter int                     HIT_COUNT   = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_CLASSES*O_BW-1:0]          data_i,
  input  logic                                 valid_i,
  input  logic                                 last_i,
  output logic                                 ready_o,
  output logic [class_bw(NUM_CLASSES)-1:0]     class_o,
  output logic [O_BW-1:0]                      score_o,
  output logic                                 wake_o,
  output logic                                 valid_o,
  output logic                                 last_o,
  input  logic                                 ready_i
);

  localparam int CLASS_BW = class_bw(NUM_CLASSES);
  localparam int IDX_BW   = class_bw(NUM_CLASSES + 1);

  wrd_state_e state_q, state_d;

  logic [NUM_CLASSES*O_BW-1:0] data_q, data_d;
  logic                        last_q, last_d;
  logic signed [O_BW-1:0]      best_q, best_d;
  logic [CLASS_BW-1:0]         best_idx_q, best_idx_d;
  logic [IDX_BW-1:0]           idx_q, idx_d;
  logic                        hit_q, hit_d;

  logic signed [O_BW-1:0]      scores [NUM_CLASSES];
  logic signed [O_BW-1:0]      cand;
  logic                        scan_done;
  logic                        accept;
  logic                        handshake;
  logic                        wake_raw;

  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_unpack
    assign scores[i] = data_q[i*O_BW +: O_BW];
  end

  // idx_q reaches NUM_CLASSES one cycle after the last comparison; that
  // extra SCAN cycle is where the result and hit flag are latched.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (idx_q == IDX_BW'(i)) begin
        cand = scores[i];
      end
    end
    scan_done = (idx_q == IDX_BW'(NUM_CLASSES));
    accept    = ready_o && valid_i;
    handshake = valid_o && ready_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = SCAN;
      SCAN:    if (scan_done) state_d = OUT;
      OUT:     if (handshake) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Strict greater-than keeps the lower index on ties.
  always_comb begin
    data_d     = data_q;
    last_d     = last_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    idx_d      = idx_q;
    hit_d      = hit_q;
    if (state_q == IDLE && accept) begin
      data_d     = data_i;
      last_d     = last_i;
      best_d     = data_i[O_BW-1:0];
      best_idx_d = '0;
      idx_d      = IDX_BW'(1);
    end else if (state_q == SCAN) begin
      if (scan_done) begin
        hit_d = (best_idx_q == CLASS_BW'(WAKE_CLASS)) && (best_q > THRESHOLD);
      end else begin
        if (cand > best_q) begin
          best_d     = cand;
          best_idx_d = CLASS_BW'(idx_q);
        end
        idx_d = idx_q + IDX_BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q     <= '0;
      last_q     <= 1'b0;
      best_q     <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
      hit_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      last_q     <= last_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      idx_q      <= idx_d;
      hit_q      <= hit_d;
    end
  end

  wake_hit_counter #(
    .HIT_COUNT (HIT_COUNT)
  ) u_hits (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .hit_i       (hit_q),
    .handshake_i (handshake),
    .wake_o      (wake_raw)
  );

  // ready_o is held low while reset is asserted so every output reads 0.
  always_comb begin
    ready_o = (state_q == IDLE) && !rst_i;
    valid_o = (state_q == OUT);
    class_o = best_idx_q;
    score_o = best_q;
    last_o  = last_q;
    wake_o  = wake_raw && valid_o;
  end

endmodule

// File: tb/tb_wake_decision.sv
// Self-checking bench for wake_decision: directed scenarios plus random frames
// compared against a plain argmax / streak reference model.
module tb_wake_decision;

  localparam int O_BW        = 24;
  localparam int NC          = 3;
  localparam int WAKE_CLASS  = 1;
  localparam int THRESHOLD   = 0;
  localparam int HIT_COUNT   = 2;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [NC*O_BW-1:0] data_i = '0;
  logic             valid_i = 1'b0;
  logic             last_i = 1'b0;
  logic             ready_o;
  logic [1:0]       class_o;
  logic [O_BW-1:0]  score_o;
  logic             wake_o;
  logic             valid_o;
  logic             last_o;
  logic             ready_i = 1'b1;

  int checks   = 0;
  int failures = 0;
  int streak   = 0;

  wake_decision dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .class_o (class_o),
    .score_o (score_o),
    .wake_o  (wake_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Send one frame, wait for its beat, optionally stall, then complete the
  // handshake. Expectations come from a straightforward argmax over the scores.
  task automatic applyStimulus(input int s0, input int s1, input int s2,
                               input logic lst, input int stall, input string tag);
    int         sc [NC];
    int         best;
    int         bidx;
    int         lat;
    logic       hit;
    logic       expWake;
    logic [23:0] expScore;
    sc[0] = s0; sc[1] = s1; sc[2] = s2;
    best = sc[0];
    bidx = 0;
    for (int i = 1; i < NC; i++) begin
      if (sc[i] > best) begin
        best = sc[i];
        bidx = i;
      end
    end
    expScore = 24'(best);
    hit      = (bidx == WAKE_CLASS) && (best > THRESHOLD);
    expWake  = hit && (streak + 1 == HIT_COUNT);

    @(negedge clk_i);
    checkOutput({tag, "_ready_before"}, 32'(ready_o), 32'd1);
    data_i  = {24'(s2), 24'(s1), 24'(s0)};
    valid_i = 1'b1;
    last_i  = lst;
    ready_i = (stall == 0);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
    lat = 0;
    while (valid_o !== 1'b1 && lat < 20) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'd3);
    checkOutput({tag, "_class"}, 32'(class_o), 32'(bidx));
    checkOutput({tag, "_score"}, 32'(score_o), 32'(expScore));
    checkOutput({tag, "_wake"}, 32'(wake_o), 32'(expWake));
    checkOutput({tag, "_last"}, 32'(last_o), 32'(lst));

    for (int k = 0; k < stall; k++) begin
      @(posedge clk_i);
      #1;
      checkOutput({tag, "_stall_beat"},
                  {2'b0, valid_o, ready_o, wake_o, last_o, class_o, score_o},
                  {2'b0, 1'b1, 1'b0, expWake, lst, 2'(bidx), expScore});
    end
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput({tag, "_valid_drop"}, 32'(valid_o), 32'd0);
    checkOutput({tag, "_ready_after"}, 32'(ready_o), 32'd1);

    if (expWake) streak = 0;
    else if (hit) streak = streak + 1;
    else streak = 0;
  endtask

  initial begin
    logic sawValid;
    int   a, b, c, mode, stall;
    logic lst;

    $display("[TB] reset and idle");
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_outputs", {26'b0, ready_o, valid_o, wake_o, last_o, class_o}, 32'd0);
    checkOutput("rst_score", 32'(score_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput("idle_ready", 32'(ready_o), 32'd1);
    sawValid = 1'b0;
    repeat (5) begin
      @(posedge clk_i);
      #1;
      if (valid_o) sawValid = 1'b1;
    end
    checkOutput("idle_no_valid", 32'(sawValid), 32'd0);

    $display("[TB] argmax, ties, negatives");
    applyStimulus(-5, 40, 12, 1'b1, 0, "argmax");
    applyStimulus(-7, -7, -9, 1'b0, 0, "tie_neg");
    applyStimulus(3, 9, 9, 1'b0, 0, "tie_pos");

    $display("[TB] wake streak");
    applyStimulus(-1, -2, -3, 1'b0, 0, "clear");
    applyStimulus(0, 10, 0, 1'b0, 0, "streak_a1");
    applyStimulus(0, 10, 0, 1'b0, 0, "streak_a2");
    applyStimulus(0, 10, 0, 1'b0, 0, "streak_a3");
    applyStimulus(-1, -2, -3, 1'b0, 0, "clear2");
    applyStimulus(0, 10, 0, 1'b0, 0, "streak_b1");
    applyStimulus(20, 10, 0, 1'b0, 0, "streak_b2");
    applyStimulus(0, 10, 0, 1'b0, 0, "streak_b3");
    applyStimulus(-4, 0, -4, 1'b0, 0, "thresh_edge");

    $display("[TB] backpressure");
    applyStimulus(0, 10, 0, 1'b0, 0, "bp_pre");
    applyStimulus(0, 10, 0, 1'b1, 10, "bp_stall");
    applyStimulus(0, 10, 0, 1'b0, 0, "bp_post");

    $display("[TB] async reset mid-scan");
    @(negedge clk_i);
    data_i  = {24'(50), 24'(30), 24'(10)};
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #2;
    checkOutput("midscan_rst", {29'b0, ready_o, valid_o, wake_o}, 32'd0);
    @(negedge clk_i);
    rst_i  = 1'b0;
    streak = 0;
    sawValid = 1'b0;
    repeat (6) begin
      @(posedge clk_i);
      #1;
      if (valid_o) sawValid = 1'b1;
    end
    checkOutput("midscan_no_beat", 32'(sawValid), 32'd0);
    applyStimulus(1, 2, 50, 1'b0, 0, "after_rst");

    $display("[TB] random frames");
    for (int n = 0; n < 40; n++) begin
      mode = int'($urandom_range(0, 4));
      a = int'($urandom_range(0, 2000)) - 1000;
      b = int'($urandom_range(0, 2000)) - 1000;
      c = int'($urandom_range(0, 2000)) - 1000;
      case (mode)
        0: b = 1000 + int'($urandom_range(0, 500));
        1: begin b = a; c = a; end
        2: begin a = 8388607; b = -8388608; end
        3: begin b = 0; a = -5; c = -5; end
        default: ;
      endcase
      lst   = ($urandom_range(0, 1) == 1);
      stall = int'($urandom_range(0, 3));
      applyStimulus(a, b, c, lst, stall, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
